// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if
//   Groups the hazard-unit inputs and the pipeline control outputs of
//   pipeline_stall_ctrl into one bundle.
//   master : pipeline side (drives ID/EX status, receives enables)
//   slave  : the stall controller
//   Inputs to controller : id_rs, id_rt, id_uses_rt, id_branch_taken,
//                          ex_mem_read, ex_rt, ex_mc_start, dmem_busy
//   Outputs of controller: stall, pc_write, if_id_write, if_id_flush,
//                          ex_hold, freeze, mc_done, stall_cycles
interface pipeline_stall_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_branch_taken;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        ex_mc_start;
    logic        dmem_busy;
    logic        stall;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        ex_hold;
    logic        freeze;
    logic        mc_done;
    logic [15:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_branch_taken,
               ex_mem_read, ex_rt, ex_mc_start, dmem_busy,
        input  stall, pc_write, if_id_write, if_id_flush,
               ex_hold, freeze, mc_done, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_branch_taken,
               ex_mem_read, ex_rt, ex_mc_start, dmem_busy,
        output stall, pc_write, if_id_write, if_id_flush,
               ex_hold, freeze, mc_done, stall_cycles
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Hazard / stall controller for a 5-stage pipeline: load-use bubbles,
//   multicycle EX holds, data-memory freeze and branch flush.
//   Parameter MC_LATENCY (2..15): total EX cycles of a multicycle op.
//   Ports: clk   - clock, rising edge
//          reset - asynchronous, active-high
//          bus   - pipeline_stall_ctrl_if.slave (see interface header)
//   Optional macro PIPELINE_STALL_CTRL_STALL_CNT_EN enables the saturating
//   stall-cycle counter; without it stall_cycles reads 0 and has no flops.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   S_RUN     | normal flow; hazard detection and branch flush active
//   S_MC_BUSY | multicycle op occupying EX; r_mc_cnt cycles remaining
module pipeline_stall_ctrl #(
    parameter int MC_LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_stall_ctrl_if.slave   bus
);
    localparam logic [0:0] S_RUN     = 1'b0;
    localparam logic [0:0] S_MC_BUSY = 1'b1;

    logic [0:0] r_state, w_state_nxt;
    logic [3:0] r_mc_cnt, w_mc_cnt_nxt;
    logic       w_hazard;
    logic       w_freeze;
    logic       w_stall, w_pc_write, w_if_id_write, w_if_id_flush;
    logic       w_ex_hold, w_mc_done;

    assign w_freeze = bus.dmem_busy;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign w_hazard = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                      ((bus.ex_rt == bus.id_rs) ||
                       (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

    always_comb begin
        w_state_nxt   = r_state;
        w_mc_cnt_nxt  = r_mc_cnt;
        w_stall       = 1'b0;
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_if_id_flush = 1'b0;
        w_ex_hold     = 1'b0;
        w_mc_done     = 1'b0;
        if (w_freeze) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_ex_hold     = 1'b1;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.ex_mc_start) begin
                        w_ex_hold     = 1'b1;
                        w_pc_write    = 1'b0;
                        w_if_id_write = 1'b0;
                        w_mc_cnt_nxt  = 4'(MC_LATENCY - 1);
                        w_state_nxt   = S_MC_BUSY;
                    end else if (w_hazard) begin
                        w_stall       = 1'b1;
                        w_pc_write    = 1'b0;
                        w_if_id_write = 1'b0;
                    end else begin
                        w_if_id_flush = bus.id_branch_taken;
                    end
                end
                default: begin
                    if (r_mc_cnt > 4'd1) begin
                        w_ex_hold     = 1'b1;
                        w_pc_write    = 1'b0;
                        w_if_id_write = 1'b0;
                        w_mc_cnt_nxt  = r_mc_cnt - 4'd1;
                    end else begin
                        // Final EX cycle: result valid, pipeline released.
                        w_mc_done     = 1'b1;
                        w_if_id_flush = bus.id_branch_taken;
                        w_mc_cnt_nxt  = 4'd0;
                        w_state_nxt   = S_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_RUN;
            r_mc_cnt <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_mc_cnt <= w_mc_cnt_nxt;
        end
    end

`ifdef PIPELINE_STALL_CTRL_STALL_CNT_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= 16'h0000;
        end else if (!w_pc_write && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
`else
    assign bus.stall_cycles = 16'h0000;
`endif

    assign bus.stall       = w_stall;
    assign bus.pc_write    = w_pc_write;
    assign bus.if_id_write = w_if_id_write;
    assign bus.if_id_flush = w_if_id_flush;
    assign bus.ex_hold     = w_ex_hold;
    assign bus.freeze      = w_freeze;
    assign bus.mc_done     = w_mc_done;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;
    // Expected-output vector bit order:
    // {stall, pc_write, if_id_write, if_id_flush, ex_hold, freeze, mc_done}
    localparam logic [6:0] E_IDLE  = 7'b0110000;
    localparam logic [6:0] E_STALL = 7'b1000000;
    localparam logic [6:0] E_FRZ   = 7'b0000110;
    localparam logic [6:0] E_FLUSH = 7'b0111000;
    localparam logic [6:0] E_HOLD  = 7'b0000100;
    localparam logic [6:0] E_DONE  = 7'b0110001;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       br;
        logic       mem_read;
        logic [4:0] ex_rt;
        logic       busy;
        logic [6:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [6:0] exp;
    } sb_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] exp_sc = 16'h0000;
    sb_t  sb_q[$];
    vec_t vecs[12];

    pipeline_stall_ctrl_if bus();

    pipeline_stall_ctrl #(.MC_LATENCY(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt,
                          input logic uses_rt, input logic br,
                          input logic mem_read, input logic [4:0] ex_rt,
                          input logic mc_start, input logic busy);
        bus.id_rs           = rs;
        bus.id_rt           = rt;
        bus.id_uses_rt      = uses_rt;
        bus.id_branch_taken = br;
        bus.ex_mem_read     = mem_read;
        bus.ex_rt           = ex_rt;
        bus.ex_mc_start     = mc_start;
        bus.dmem_busy       = busy;
    endtask

    // Push expectation, sample on the falling edge, then advance one clock.
    task automatic step(input string name, input logic [6:0] exp);
        sb_t e;
        logic [6:0] act;
        sb_q.push_back('{name: name, exp: exp});
        @(negedge clk);
        e = sb_q.pop_front();
        act = {bus.stall, bus.pc_write, bus.if_id_write, bus.if_id_flush,
               bus.ex_hold, bus.freeze, bus.mc_done};
        checks++;
        if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: outputs got %b required %b", e.name, act, e.exp);
        end
        checks++;
        if (bus.stall_cycles !== exp_sc) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d required %0d",
                     e.name, bus.stall_cycles, exp_sc);
        end
        @(posedge clk);
        #1;
`ifdef PIPELINE_STALL_CTRL_STALL_CNT_EN
        if (!reset && !e.exp[5] && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
`endif
    endtask

    initial begin
        vecs[0]  = '{"idle",            5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, E_IDLE};
        vecs[1]  = '{"load_use_rs",     5'd5, 5'd2, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, E_STALL};
        vecs[2]  = '{"after_bubble",    5'd5, 5'd2, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, E_IDLE};
        vecs[3]  = '{"load_use_rt",     5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, E_STALL};
        vecs[4]  = '{"rt_not_used",     5'd3, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, E_IDLE};
        vecs[5]  = '{"ex_rt_zero_rs",   5'd0, 5'd4, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, E_IDLE};
        vecs[6]  = '{"ex_rt_zero_rt",   5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, E_IDLE};
        vecs[7]  = '{"no_load",         5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, E_IDLE};
        vecs[8]  = '{"branch_hazard",   5'd8, 5'd1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, E_STALL};
        vecs[9]  = '{"branch_flush",    5'd8, 5'd1, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, E_FLUSH};
        vecs[10] = '{"freeze_hz_br",    5'd8, 5'd1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, E_FRZ};
        vecs[11] = '{"freeze_only",     5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, E_FRZ};

        reset = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        #12;
        step("reset_state", E_IDLE);
        reset = 1'b0;
        step("post_reset_idle", E_IDLE);

        foreach (vecs[i]) begin
            set_in(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].br,
                   vecs[i].mem_read, vecs[i].ex_rt, 1'b0, vecs[i].busy);
            step(vecs[i].name, vecs[i].exp);
        end

        // Multicycle op, latency 4; a second start pulse in MC_BUSY is ignored.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        step("mc_start", E_HOLD);
        step("mc_hold2_restart_ignored", E_HOLD);
        bus.ex_mc_start = 1'b0;
        step("mc_hold3", E_HOLD);
        step("mc_done", E_DONE);
        step("mc_back_run", E_IDLE);

        // Freeze in MC_BUSY at mc_cnt=2 delays mc_done by two cycles.
        bus.ex_mc_start = 1'b1;
        step("mcf_start", E_HOLD);
        bus.ex_mc_start = 1'b0;
        step("mcf_hold_cnt3", E_HOLD);
        bus.dmem_busy = 1'b1;
        step("mcf_freeze1", E_FRZ);
        step("mcf_freeze2", E_FRZ);
        bus.dmem_busy = 1'b0;
        step("mcf_hold_cnt2", E_HOLD);
        step("mcf_done", E_DONE);
        step("mcf_back_run", E_IDLE);

        // Freeze outranks a start request in RUN: the op is not entered.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        step("freeze_over_start", E_FRZ);
        set_in(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        step("start_not_taken", E_FLUSH);

        // Reset mid-MC_BUSY abandons the op with no mc_done.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        step("mcr_start", E_HOLD);
        bus.ex_mc_start = 1'b0;
        step("mcr_hold", E_HOLD);
        #2;
        reset  = 1'b1;
        exp_sc = 16'h0000;
        step("mcr_in_reset", E_IDLE);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) step("mcr_no_done", E_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 Parameter: MC_LATENCY, 4, total EX-stage cycles of a multicycle (mult/div) op; legal range 2..15.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: id_rs, id_rt  in  5 each  source registers of the instruction in ID.
REQ-005 Port: id_uses_rt  in  1  ID instruction reads rt as a source.
REQ-006 Port: id_branch_taken  in  1  branch/jump resolved taken in ID.
REQ-007 Port: ex_mem_read  in  1  instruction in EX is a load.
REQ-008 Port: ex_rt  in  5  load destination register in EX.
REQ-009 Port: ex_mc_start  in  1  multicycle op present in EX (first cycle).
REQ-010 Port: dmem_busy  in  1  data memory not ready; pipeline must freeze.
REQ-011 Port: stall  out  1  bubble select to the ID/EX control mux (1 = zero control word).
REQ-012 Port: pc_write, if_id_write  out  1 each  PC / IF-ID register enables.
REQ-013 Port: if_id_flush  out  1  clear IF/ID to NOP.
REQ-014 Port: ex_hold  out  1  hold ID/EX and EX/MEM registers.
REQ-015 Port: freeze  out  1  hold every pipeline register.
REQ-016 Port: mc_done  out  1  one-cycle pulse: multicycle result valid this cycle.
REQ-017 Port: stall_cycles  out  16  stall performance counter (see Configuration).

Function
REQ-018 States: RUN, MC_BUSY; 4-bit down-counter mc_cnt.
REQ-019 Priority per cycle: freeze > multicycle > load-use stall > flush.
REQ-020 freeze = dmem_busy (combinational, any state); while 1: pc_write=0, if_id_write=0, ex_hold=1, stall=0, if_id_flush=0, mc_done=0; state and mc_cnt unchanged.
REQ-021 RUN idle outputs: stall=0, pc_write=1, if_id_write=1, if_id_flush=0, ex_hold=0, mc_done=0.
REQ-022 Load-use hazard (RUN, freeze=0, ex_mc_start=0): ex_mem_read=1, ex_rt!=0, and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)); same cycle stall=1, pc_write=0, if_id_write=0; exactly one bubble per load.
REQ-023 ex_rt==0 never raises a hazard.
REQ-024 RUN, freeze=0, ex_mc_start=1: ex_hold=1, pc_write=0, if_id_write=0, stall=0; load mc_cnt=MC_LATENCY-1; next state MC_BUSY.
REQ-025 MC_BUSY, freeze=0, mc_cnt>1: ex_hold=1, pc_write=0, if_id_write=0; mc_cnt decrements.
REQ-026 MC_BUSY, freeze=0, mc_cnt==1: mc_done=1, ex_hold=0, pc_write=1, if_id_write=1; next state RUN; total EX occupancy = MC_LATENCY cycles.
REQ-027 ex_mc_start is sampled only in RUN with freeze=0; ignored in MC_BUSY.
REQ-028 if_id_flush = id_branch_taken only when stall=0, ex_hold=0, freeze=0; otherwise 0 (branch re-evaluated after stall).
REQ-029 Hazard detection and flush are combinational (zero latency); only state, mc_cnt, stall_cycles are registered.

Reset
REQ-030 reset=1 forces state=RUN, mc_cnt=0, stall_cycles=0 immediately, independent of clk; outputs take RUN values from REQ-020/021 with current inputs.
REQ-031 reset asserted mid-MC_BUSY abandons the op; no mc_done is produced.

Configuration
REQ-032 Macro PIPELINE_STALL_CTRL_STALL_CNT_EN: defined -> stall_cycles increments each clock with pc_write=0 (any cause), saturating at 16'hFFFF, cleared only by reset.
REQ-033 Macro undefined -> stall_cycles tied to 16'h0000, no counter flops; all other behaviour identical.

Verification
REQ-034 ex_mem_read=1, ex_rt=5, id_rs=5 -> one cycle stall=1, pc_write=0, if_id_write=0; next cycle (ex_mem_read=0) idle outputs.
REQ-035 ex_mem_read=1, ex_rt=0, id_rs=0 -> stall=0, pc_write=1.
REQ-036 MC_LATENCY=4, ex_mc_start pulse -> ex_hold=1 for 3 cycles, then mc_done=1 with ex_hold=0 on 4th cycle, back to RUN.
REQ-037 dmem_busy=1 for 2 cycles in MC_BUSY with mc_cnt=2 -> freeze=1 both cycles, mc_cnt stays 2; mc_done 2 cycles later than unfrozen.
REQ-038 id_branch_taken=1 with concurrent load-use hazard -> if_id_flush=0, stall=1; next cycle with hazard clear -> if_id_flush=1.
REQ-039 reset pulse mid-MC_BUSY (macro defined, stall_cycles=7) -> state RUN, stall_cycles=0, no mc_done.
